stream_mux_rr: RTL and testbench

Parametrised N-channel, DATA_W-bit streaming multiplexer with one registered output stage and valid/ready handshakes on every input and the output. It generalises the 8:1 enable-gated select mux by adding:
- a round-robin arbitration mode alongside fixed-select mode;
- per-channel backpressure.

It sits between several producer streams and one consumer, e.g. funnelling sensor or UART channels into a single shared sink.

---
 rtl/stream_mux_rr.sv | 127 ++++++++++++
 tb/tb_stream_mux_rr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N_CH-input, DATA_W-bit streaming multiplexer with one registered output
//   stage. The source channel is picked either by a fixed index (mode = 0)
//   or by a round-robin scan that starts at a rotating pointer (mode = 1).
//   Every input and the output use valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en         arbitration enable; 0 blocks new grants
//   mode       0 = fixed select by sel, 1 = round-robin
//   sel        channel index used in fixed-select mode
//   in_data    channel k at bits [k*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero (combinational)
//   out_data   registered output data
//   out_ch     index of the channel that produced out_data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the held beat

module stream_mux_rr #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  cand;
    logic              cand_found;
    logic [DATA_W-1:0] cand_data;
    logic [SEL_W:0]    scan;
    logic              free;
    logic              load;
    logic [SEL_W-1:0]  ptr_next;

    // The slot can take a new beat when empty or when the held beat leaves
    // this same cycle, which gives back-to-back transfers with no bubble.
    assign free = !out_valid || out_ready;

    // Candidate selection.
    always_comb begin
        // NOTE: every variable gets a default before any branch so the
        // combinational block can never infer a latch.
        cand       = '0;
        cand_found = 1'b0;
        scan       = '0;
        if (!mode) begin
            // An index past the last channel (N_CH not a power of two)
            // never grants.
            if (({1'b0, sel} < (SEL_W+1)'(N_CH)) && in_valid[sel]) begin
                cand       = sel;
                cand_found = 1'b1;
            end
        end else begin
            // Scan ptr, ptr+1, ... wrapping modulo N_CH; first valid wins.
            for (int i = 0; i < N_CH; i++) begin
                scan = {1'b0, ptr} + (SEL_W+1)'(i);
                if (scan >= (SEL_W+1)'(N_CH))
                    scan = scan - (SEL_W+1)'(N_CH);
                if (!cand_found && in_valid[scan[SEL_W-1:0]]) begin
                    cand       = scan[SEL_W-1:0];
                    cand_found = 1'b1;
                end
            end
        end
    end

    // Data of the winning channel.
    always_comb begin
        cand_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cand == SEL_W'(k))
                cand_data = in_data[k*DATA_W +: DATA_W];
        end
    end

    // rst is folded in so no input sees ready while reset is held.
    assign load = !rst && en && free && cand_found;

    always_comb begin
        in_ready = '0;
        if (load)
            in_ready[cand] = 1'b1;
    end

    assign ptr_next = (cand == SEL_W'(N_CH-1)) ? '0 : cand + SEL_W'(1);

    // Output register and round-robin pointer. The FULL/EMPTY state is
    // simply out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: only this handful of control/data flops exists, so all
            // of it is reset; a held beat is discarded on reset.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from
            // the pre-edge values, whatever the statement order.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= cand_data;
                out_ch    <= cand;
                ptr       <= ptr_next;
            end else if (out_ready) begin
                // Beat accepted (or slot already empty) and nothing new:
                // drop valid, keep data/channel as they were.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
//   Directed bench for stream_mux_rr. A small arbiter model predicts each
//   grant; granted beats are pushed to a scoreboard queue and compared
//   against the DUT output register. A second instance with N_CH = 6
//   covers an out-of-range fixed select.

module tb_stream_mux_rr;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          mode;
    logic [SW-1:0] sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready;

    logic [2:0]    sel6;
    logic [6*W-1:0] in_data6;
    logic [5:0]    in_valid6;
    logic [5:0]    in_ready6;
    logic [W-1:0]  out_data6;
    logic [2:0]    out_ch6;
    logic          out_valid6;

    beat_t sb[$];
    int    m_ptr;
    int    n_vec = 0;
    int    n_err = 0;
    int    ready_cnt[N];

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(6), .DATA_W(W)) dut6 (
        .clk(clk), .rst(rst), .en(en), .mode(1'b0), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbiter: channel that should be granted, -1 for none.
    function automatic int model_grant();
        if (!mode)
            return in_valid[sel] ? int'(sel) : -1;
        for (int i = 0; i < N; i++) begin
            if (in_valid[(m_ptr + i) % N])
                return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        int         g;
        bit         free;
        logic [7:0] exp_ready;
        #1;
        if (sb.size() > 0) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_data", 32'(out_data), 32'(sb[0].data));
            chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
        end else begin
            chk("out_valid", 32'(out_valid), 32'd0);
        end
        free = (sb.size() == 0) || out_ready;
        g = (en && free) ? model_grant() : -1;
        exp_ready = (g >= 0) ? (8'd1 << g) : 8'd0;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        for (int k = 0; k < N; k++)
            if (in_ready[k]) ready_cnt[k]++;
        if (out_ready && sb.size() > 0)
            void'(sb.pop_front());
        if (g >= 0) begin
            sb.push_back('{ch: g, data: in_data[g*W +: W]});
            m_ptr = (g == N-1) ? 0 : g + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        in_valid  = '0;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'hA0 + 8'(k);
        sel6      = 3'd7;
        in_valid6 = 6'h3F;
        for (int k = 0; k < 6; k++) in_data6[k*W +: W] = 8'h60 + 8'(k);
        m_ptr     = 0;

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed select, sel stepped 0..7, all channels valid.
        in_valid = 8'hFF;
        for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            cycle();
            chk("fixed_data", 32'(out_data), 32'hA0 + 32'(s));
            chk("fixed_ch", 32'(out_ch), 32'(s));
        end

        // Round-robin, all valid, 16 cycles.
        mode = 1'b1;
        for (int k = 0; k < N; k++) ready_cnt[k] = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("rr_ch", 32'(out_ch), 32'(i % N));
        end
        for (int k = 0; k < N; k++) chk("rr_ready_count", 32'(ready_cnt[k]), 32'd2);

        // Sparse round-robin: channels 2 and 5.
        in_valid = 8'b0010_0100;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("sparse_ch", 32'(out_ch), (i % 2 == 0) ? 32'd2 : 32'd5);
        end

        // Backpressure: hold 3C for 5 cycles, then release.
        in_valid = '0;
        cycle();
        mode = 1'b0;
        sel  = 3'd3;
        in_data[3*W +: W] = 8'h3C;
        in_valid  = 8'b0000_1000;
        out_ready = 1'b0;
        cycle();
        in_data[3*W +: W] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_hold_data", 32'(out_data), 32'h3C);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_next_data", 32'(out_data), 32'h55);
        in_valid = '0;
        cycle();
        cycle();

        // Enable low while a beat is held.
        out_ready = 1'b0;
        sel       = 3'd1;
        in_valid  = 8'b0000_0010;
        cycle();
        en       = 1'b0;
        in_valid = 8'hFF;
        cycle();
        out_ready = 1'b1;
        cycle();
        chk("en_drained", 32'(out_valid), 32'd0);
        cycle();
        cycle();
        en = 1'b1;
        cycle();
        chk("en_resume", 32'(out_valid), 32'd1);

        // Six-channel instance: select 7 never grants, select 5 does.
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("n6_ready", 32'(in_ready6), 32'd0);
            cycle();
            chk("n6_valid", 32'(out_valid6), 32'd0);
        end
        sel6 = 3'd5;
        cycle();
        chk("n6_sel5_valid", 32'(out_valid6), 32'd1);
        chk("n6_sel5_data", 32'(out_data6), 32'h65);

        // Asynchronous reset mid-stream.
        mode     = 1'b1;
        in_valid = 8'hFF;
        for (int i = 0; i < 3; i++) cycle();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        sb.delete();
        m_ptr = 0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 8'b0100_1000;
        cycle();
        chk("arst_first_ch", 32'(out_ch), 32'd3);
        cycle();
        chk("arst_second_ch", 32'(out_ch), 32'd6);
        in_valid = '0;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
